vexec_seq: RTL and testbench
============================

// Module: vexec_seq
// PURPOSE
//   Vector execute sequencer that sits between the issue stage and the vector ALU.
//   Accepts one vector arithmetic instruction, reads the operand register groups from the VRF,
//   drives the vector ALU, and writes results back to the VRF, one register per 3-cycle step.
//   Supports vector-vector (.vv) and vector-scalar (.vx) forms, LMUL 1/2/4/8.
// PARAMETERS
//   VLEN   128  vector register width in bits
//   XLEN   32   scalar operand width in bits
// PORTS
//   i_clk          in   1     clock
//   i_rst          in   1     asynchronous reset, active-high
//   i_req_valid    in   1     request valid
//   o_req_ready    out  1     request ready; high only in IDLE
//   i_req_ctrl     in   6     ALU op code (AND 04,OR 05,XOR 06,ADD 00,SUB 01,SLT 02,SLTU 03,SLL 18,SRL 19,SRA 1A)
//   i_req_sew      in   11    element width in bits, one-hot: 8,16,32,64,128
//   i_req_lmul     in   2     0..3 -> group of 1,2,4,8 registers
//   i_req_vx       in   1     1 = operand B is the splatted scalar, 0 = vs1
//   i_req_vd/vs1/vs2 in 5     register numbers
//   i_req_scalar   in   XLEN  scalar operand
//   o_vrf_ra1/ra2  out  5     VRF read addresses (ra1 = vs2+k, ra2 = vs1+k); sync read, 1-cycle latency
//   i_vrf_rd1/rd2  in   VLEN  VRF read data
//   o_alu_sew      out  11    to ALU
//   o_alu_ctrl     out  6     to ALU
//   o_alu_dataa    out  VLEN  to ALU (vs2 element group)
//   o_alu_datab    out  VLEN  to ALU (vs1 or splat)
//   i_alu_result   in   VLEN  from ALU (combinational)
//   o_vrf_we       out  1     VRF write enable
//   o_vrf_wa       out  5     VRF write address (vd+k)
//   o_vrf_wd       out  VLEN  VRF write data
//   o_busy         out  1     high in any state other than IDLE
//   o_done         out  1     1-cycle pulse at instruction end
//   o_err          out  1     1-cycle pulse with o_done when request was illegal
// BEHAVIOUR
//   - Reset: state IDLE; o_req_ready=1; all other outputs 0; step counter k=0.
//   - Handshake: accept on edge where i_req_valid && o_req_ready. All req fields are latched at that
//     edge; later changes on req inputs are ignored.
//   - States: IDLE -> CHECK -> {READ -> EXEC -> WB}xN -> DONE -> IDLE. N = 1<<lmul.
//   - CHECK (1 cycle): illegal if sew not one-hot in {8..128}, sew>VLEN, vd/vs1/vs2 not multiple of N,
//     or any of vd/vs1/vs2 +N > 32 (vs1 ignored when vx). Illegal -> DONE with o_err=1, no VRF writes.
//   - READ: drive ra1=vs2+k, ra2=vs1+k.
//   - EXEC: register o_alu_dataa<=i_vrf_rd1; o_alu_datab<=vx ? splat : i_vrf_rd2; o_alu_sew/ctrl from latch.
//   - WB: o_vrf_we=1, o_vrf_wa=vd+k, o_vrf_wd=i_alu_result; k++; if k==N-1 -> DONE else READ.
//   - Timing: accept at edge T -> CHECK in T+1, first WB in cycle T+4, WB k in T+4+3k, DONE (o_done)
//     in cycle T+3N+2; o_req_ready rises the cycle after DONE.
//   - Splat: scalar truncated to SEW low bits and replicated across VLEN; SEW>XLEN sign-extends the scalar.
//   - Overlap vd with vs1/vs2: legal; the written register is re-read only if k order revisits it (no hazard
//     interlock, result is whatever the VRF returns).
//   - Reset mid-operation: returns to IDLE immediately; registers already written stay written; no o_done.
//   - o_vrf_we is 0 in every state except WB.
// CONFIGURATION
//   VEXEC_SEQ_PERF_EN defined: adds o_perf_insts[31:0] (completed instructions incl. errored) and
//     o_perf_wr[31:0] (VRF writes); both reset to 0, wrap at 2^32.
//   Undefined: counters are not built; the two ports are tied to 0.
// STRUCTURE
//   Shared package vec_pkg: ALU op-code constants, SEW one-hot constants, LMUL encoding, state enum.
//   Sub-module vexec_splat: combinational scalar->VLEN replication by SEW (XLEN/VLEN params).
//   The ALU is outside this block; this block contains no arithmetic except address/counter increments.
// TESTING
//   1. ADD .vv sew=8 lmul=0 vd=1 vs2=2 (all 0x01) vs1=3 (all 0x02) -> single write v1=0x0303..03 in T+4, o_done T+5.
//   2. SUB .vx sew=32 scalar=5, vs2 lanes=3 -> write lanes 0xFFFFFFFE; ra2 ignored.
//   3. ADD lmul=2 vd=8 vs2=16 vs1=24 -> writes v8,v9,v10,v11 in T+4,7,10,13; ra1 16..19; o_done T+14.
//   4. sew=11'h18 -> no o_vrf_we, o_done and o_err together at T+2; ready again at T+3.
//   5. lmul=1, vd=9 (misaligned) -> o_err; vd=30, lmul=2 -> o_err (group overflow).
//   6. lmul=1; assert i_rst during EXEC of k=1 -> next cycle IDLE, only v(vd) written, no o_done; new request accepted.
//   7. (PERF_EN) run tests 1+3 -> o_perf_insts=2, o_perf_wr=5.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, state encoding and SEW decode for the vector execute sequencer
package vec_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_SLT  = 6'h02;
    localparam logic [5:0] OP_SLTU = 6'h03;
    localparam logic [5:0] OP_AND  = 6'h04;
    localparam logic [5:0] OP_OR   = 6'h05;
    localparam logic [5:0] OP_XOR  = 6'h06;
    localparam logic [5:0] OP_SLL  = 6'h18;
    localparam logic [5:0] OP_SRL  = 6'h19;
    localparam logic [5:0] OP_SRA  = 6'h1A;

    localparam logic [10:0] SEW_8   = 11'd8;
    localparam logic [10:0] SEW_16  = 11'd16;
    localparam logic [10:0] SEW_32  = 11'd32;
    localparam logic [10:0] SEW_64  = 11'd64;
    localparam logic [10:0] SEW_128 = 11'd128;

    localparam logic [1:0] LMUL_1 = 2'd0;
    localparam logic [1:0] LMUL_2 = 2'd1;
    localparam logic [1:0] LMUL_4 = 2'd2;
    localparam logic [1:0] LMUL_8 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_DONE
    } state_t;

    // Element width in bits for a legal one-hot SEW code; 0 flags an unsupported code.
    function automatic int sew_width(input logic [10:0] sew);
        case (sew)
            SEW_8:   return 8;
            SEW_16:  return 16;
            SEW_32:  return 32;
            SEW_64:  return 64;
            SEW_128: return 128;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vexec_splat.sv
// rtl/vexec_splat.sv - replicates a scalar across a vector register at the selected element width
module vexec_splat
    import vec_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int XLEN = 32
) (
    input  logic [10:0]     sew,
    input  logic [XLEN-1:0] scalar,
    output logic [VLEN-1:0] data
);

    localparam int XLEN_W = $clog2(XLEN);

    int w;
    int pos;

    // Each bit takes its position within the element; positions above XLEN repeat the sign bit.
    always_comb begin
        data = '0;
        pos  = 0;
        w    = sew_width(sew);
        if (w == 0) begin
            w = VLEN;
        end
        for (int i = 0; i < VLEN; i++) begin
            pos = i & (w - 1);
            if (pos < XLEN) begin
                data[i] = scalar[pos[XLEN_W-1:0]];
            end else begin
                data[i] = scalar[XLEN-1];
            end
        end
    end

endmodule

// File: rtl/vexec_seq.sv
// rtl/vexec_seq.sv - vector execute sequencer (READ/EXEC/WB per register); VEXEC_SEQ_PERF_EN adds counters
module vexec_seq
    import vec_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [5:0]      i_req_ctrl,
    input  logic [10:0]     i_req_sew,
    input  logic [1:0]      i_req_lmul,
    input  logic            i_req_vx,
    input  logic [4:0]      i_req_vd,
    input  logic [4:0]      i_req_vs1,
    input  logic [4:0]      i_req_vs2,
    input  logic [XLEN-1:0] i_req_scalar,
    output logic [4:0]      o_vrf_ra1,
    output logic [4:0]      o_vrf_ra2,
    input  logic [VLEN-1:0] i_vrf_rd1,
    input  logic [VLEN-1:0] i_vrf_rd2,
    output logic [10:0]     o_alu_sew,
    output logic [5:0]      o_alu_ctrl,
    output logic [VLEN-1:0] o_alu_dataa,
    output logic [VLEN-1:0] o_alu_datab,
    input  logic [VLEN-1:0] i_alu_result,
    output logic            o_vrf_we,
    output logic [4:0]      o_vrf_wa,
    output logic [VLEN-1:0] o_vrf_wd,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [31:0]     o_perf_insts,
    output logic [31:0]     o_perf_wr
);

    state_t          state;
    state_t          state_nx;
    logic [5:0]      ctrl_q;
    logic [10:0]     sew_q;
    logic [1:0]      lmul_q;
    logic            vx_q;
    logic [4:0]      vd_q;
    logic [4:0]      vs1_q;
    logic [4:0]      vs2_q;
    logic [XLEN-1:0] scalar_q;
    logic [2:0]      k;
    logic [2:0]      last_k;
    logic [5:0]      grp;
    logic            err_q;
    logic            illegal;
    logic            accept;
    logic [VLEN-1:0] splat;

    assign accept = i_req_valid && (state == ST_IDLE);
    assign last_k = {lmul_q == 2'd3, lmul_q[1], |lmul_q};
    assign grp    = 6'd1 << lmul_q;

    // A register group must start on a multiple of its size and stay inside v0..v31.
    function automatic logic reg_bad(input logic [4:0] r, input logic [5:0] n);
        return ((({1'b0, r}) & (n - 6'd1)) != 6'd0) || (({1'b0, r} + n) > 6'd32);
    endfunction

    // Legality of the latched request; vs1 is irrelevant for the scalar form.
    always_comb begin
        illegal = (sew_width(sew_q) == 0) || (sew_width(sew_q) > VLEN)
                  || reg_bad(vd_q, grp) || reg_bad(vs2_q, grp)
                  || (!vx_q && reg_bad(vs1_q, grp));
    end

    vexec_splat #(
        .VLEN(VLEN),
        .XLEN(XLEN)
    ) u_splat (
        .sew   (sew_q),
        .scalar(scalar_q),
        .data  (splat)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state sequencing: one READ/EXEC/WB round per register of the group.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_CHECK;
            ST_CHECK: state_nx = illegal ? ST_DONE : ST_READ;
            ST_READ:  state_nx = ST_EXEC;
            ST_EXEC:  state_nx = ST_WB;
            ST_WB:    state_nx = (k == last_k) ? ST_DONE : ST_READ;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Request latch, step counter, error flag and the registered ALU operands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_q      <= '0;
            sew_q       <= '0;
            lmul_q      <= '0;
            vx_q        <= 1'b0;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            scalar_q    <= '0;
            k           <= '0;
            err_q       <= 1'b0;
            o_alu_sew   <= '0;
            o_alu_ctrl  <= '0;
            o_alu_dataa <= '0;
            o_alu_datab <= '0;
        end else begin
            if (accept) begin
                ctrl_q   <= i_req_ctrl;
                sew_q    <= i_req_sew;
                lmul_q   <= i_req_lmul;
                vx_q     <= i_req_vx;
                vd_q     <= i_req_vd;
                vs1_q    <= i_req_vs1;
                vs2_q    <= i_req_vs2;
                scalar_q <= i_req_scalar;
                k        <= '0;
                err_q    <= 1'b0;
            end
            if (state == ST_CHECK) begin
                err_q <= illegal;
            end
            if (state == ST_EXEC) begin
                o_alu_sew   <= sew_q;
                o_alu_ctrl  <= ctrl_q;
                o_alu_dataa <= i_vrf_rd1;
                o_alu_datab <= vx_q ? splat : i_vrf_rd2;
            end
            if (state == ST_WB) begin
                k <= k + 3'd1;
            end
        end
    end

    // Handshake, status and VRF port drive; addresses and writes are zero outside their states.
    always_comb begin
        o_req_ready = (state == ST_IDLE);
        o_busy      = (state != ST_IDLE);
        o_done      = (state == ST_DONE);
        o_err       = (state == ST_DONE) && err_q;
        o_vrf_ra1   = (state == ST_READ) ? vs2_q + {2'b00, k} : 5'd0;
        o_vrf_ra2   = (state == ST_READ) ? vs1_q + {2'b00, k} : 5'd0;
        o_vrf_we    = (state == ST_WB);
        o_vrf_wa    = (state == ST_WB) ? vd_q + {2'b00, k} : 5'd0;
        o_vrf_wd    = (state == ST_WB) ? i_alu_result : '0;
    end

`ifdef VEXEC_SEQ_PERF_EN
    // Instruction and write-back counters; both wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_perf_insts <= '0;
            o_perf_wr    <= '0;
        end else begin
            if (state == ST_DONE) o_perf_insts <= o_perf_insts + 32'd1;
            if (state == ST_WB)   o_perf_wr    <= o_perf_wr + 32'd1;
        end
    end
`else
    assign o_perf_insts = '0;
    assign o_perf_wr    = '0;
`endif

endmodule

// File: tb/tb_vexec_seq.sv
// tb/tb_vexec_seq.sv - scoreboard bench for vexec_seq with a VRF and ALU model
module tb_vexec_seq;
    import vec_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_ctrl;
    logic [10:0]  req_sew;
    logic [1:0]   req_lmul;
    logic         req_vx;
    logic [4:0]   req_vd, req_vs1, req_vs2;
    logic [31:0]  req_scalar;
    logic [4:0]   ra1, ra2;
    logic [127:0] rd1, rd2;
    logic [10:0]  alu_sew;
    logic [5:0]   alu_ctrl;
    logic [127:0] dataa, datab, alu_result;
    logic         we;
    logic [4:0]   wa;
    logic [127:0] wd;
    logic         busy, done, err;
    logic [31:0]  perf_insts, perf_wr;

    logic [127:0] vrf [32];
    logic         pl_we = 1'b0;
    logic [4:0]   pl_a = '0;
    logic [127:0] pl_d = '0;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    typedef struct { logic [4:0] wa; logic [127:0] wd; int cyc; } wr_t;
    typedef struct { logic err; int cyc; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    vexec_seq #(.VLEN(128), .XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_ctrl(req_ctrl), .i_req_sew(req_sew), .i_req_lmul(req_lmul), .i_req_vx(req_vx),
        .i_req_vd(req_vd), .i_req_vs1(req_vs1), .i_req_vs2(req_vs2), .i_req_scalar(req_scalar),
        .o_vrf_ra1(ra1), .o_vrf_ra2(ra2), .i_vrf_rd1(rd1), .i_vrf_rd2(rd2),
        .o_alu_sew(alu_sew), .o_alu_ctrl(alu_ctrl), .o_alu_dataa(dataa), .o_alu_datab(datab),
        .i_alu_result(alu_result), .o_vrf_we(we), .o_vrf_wa(wa), .o_vrf_wd(wd),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_perf_insts(perf_insts), .o_perf_wr(perf_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read register file; preload port used only while the DUT is not writing.
    always @(posedge clk) begin
        rd1 <= vrf[ra1];
        rd2 <= vrf[ra2];
        if (we) vrf[wa] <= wd;
        else if (pl_we) vrf[pl_a] <= pl_d;
    end

    function automatic logic [127:0] alu_model(input logic [5:0] op, input logic [10:0] sew,
                                               input logic [127:0] a, input logic [127:0] b);
        int w;
        logic [127:0] m, ea, eb, er, r;
        r = '0;
        er = '0;
        w = (sew == 11'd8 || sew == 11'd16 || sew == 11'd32 || sew == 11'd64) ? int'(sew) : 128;
        m = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        for (int i = 0; i < 128 / w; i++) begin
            ea = (a >> (i * w)) & m;
            eb = (b >> (i * w)) & m;
            case (op)
                OP_ADD:  er = ea + eb;
                OP_SUB:  er = ea - eb;
                OP_XOR:  er = ea ^ eb;
                default: er = '0;
            endcase
            r = r | ((er & m) << (i * w));
        end
        return r;
    endfunction

    assign alu_result = alu_model(alu_ctrl, alu_sew, dataa, datab);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", {123'd0, wa}, 128'h0FFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", {123'd0, wa}, {123'd0, e.wa});
                    chk("wr_data", wd, e.wd);
                    chk("wr_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 128'd1, 128'd0);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    chk("done_err", {127'd0, err}, {127'd0, e.err});
                    chk("done_cycle", 128'(cyc), 128'(e.cyc));
                end
            end else begin
                if (err) chk("err_without_done", 128'd1, 128'd0);
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [127:0] d);
        pl_a = a;
        pl_d = d;
        pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic [5:0] c, input logic [10:0] s, input logic [1:0] l,
                         input logic x, input logic [4:0] d, input logic [4:0] v1,
                         input logic [4:0] v2, input logic [31:0] sc, output int t);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 128'd0, 128'd1);
        req_ctrl = c; req_sew = s; req_lmul = l; req_vx = x;
        req_vd = d; req_vs1 = v1; req_vs2 = v2; req_scalar = sc;
        req_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_ctrl = 6'h3F; req_sew = 11'h7FF; req_lmul = 2'd3; req_vx = ~x;
        req_vd = 5'h1F; req_vs1 = 5'h1F; req_vs2 = 5'h1F; req_scalar = 32'hDEADBEEF;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [127:0] d, input int c);
        wr_t e;
        e.wa = a; e.wd = d; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic push_dn(input logic e_err, input int c);
        dn_t e;
        e.err = e_err; e.cyc = c;
        dq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || dq.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 128'd0, 128'd1);
    endtask

    task automatic run_t1();
        int t;
        issue(OP_ADD, SEW_8, LMUL_1, 1'b0, 5'd1, 5'd3, 5'd2, 32'd0, t);
        push_wr(5'd1, {16{8'h03}}, t + 4);
        push_dn(1'b0, t + 5);
        drain();
    endtask

    task automatic run_t3();
        int t;
        issue(OP_ADD, SEW_32, LMUL_4, 1'b0, 5'd8, 5'd24, 5'd16, 32'd0, t);
        push_wr(5'd8,  {4{32'h11}}, t + 4);
        push_wr(5'd9,  {4{32'h12}}, t + 7);
        push_wr(5'd10, {4{32'h13}}, t + 10);
        push_wr(5'd11, {4{32'h14}}, t + 13);
        push_dn(1'b0, t + 14);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        req_valid = 1'b0; req_ctrl = '0; req_sew = '0; req_lmul = '0; req_vx = 1'b0;
        req_vd = '0; req_vs1 = '0; req_vs2 = '0; req_scalar = '0;
        @(negedge clk);
        preload(5'd2, {16{8'h01}});
        preload(5'd3, {16{8'h02}});
        preload(5'd4, {4{32'h3}});
        preload(5'd5, {16{8'hA5}});
        preload(5'd12, {2{64'h2}});
        preload(5'd21, {4{32'hDEAD}});
        for (int j = 0; j < 4; j++) begin
            preload(5'(16 + j), {4{32'(j + 1)}});
            preload(5'(24 + j), {4{32'h10}});
        end
        chk("rst_ready", {127'd0, req_ready}, 128'd1);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_we", {127'd0, we}, 128'd0);
        chk("rst_ra1", {123'd0, ra1}, 128'd0);
        chk("rst_dataa", dataa, 128'd0);
        chk("rst_perf", {64'd0, perf_insts, perf_wr}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        run_t1();

        issue(OP_SUB, SEW_32, LMUL_1, 1'b1, 5'd6, 5'd5, 5'd4, 32'd5, t);
        push_wr(5'd6, {4{32'hFFFFFFFE}}, t + 4);
        push_dn(1'b0, t + 5);
        drain();

        issue(OP_ADD, SEW_64, LMUL_1, 1'b1, 5'd7, 5'd9, 5'd12, 32'hFFFFFFFF, t);
        push_wr(5'd7, {2{64'h1}}, t + 4);
        push_dn(1'b0, t + 5);
        drain();

        issue(OP_XOR, SEW_8, LMUL_1, 1'b1, 5'd13, 5'd0, 5'd2, 32'h00001234, t);
        push_wr(5'd13, {16{8'h35}}, t + 4);
        push_dn(1'b0, t + 5);
        drain();

        run_t3();

        issue(OP_ADD, 11'h18, LMUL_1, 1'b0, 5'd1, 5'd3, 5'd2, 32'd0, t);
        push_dn(1'b1, t + 2);
        @(negedge clk);
        chk("bad_sew_ready_t2", {127'd0, req_ready}, 128'd0);
        @(negedge clk);
        chk("bad_sew_ready_t3", {127'd0, req_ready}, 128'd1);
        drain();

        issue(OP_ADD, SEW_32, LMUL_2, 1'b0, 5'd9, 5'd24, 5'd16, 32'd0, t);
        push_dn(1'b1, t + 2);
        drain();

        issue(OP_ADD, SEW_32, LMUL_4, 1'b0, 5'd30, 5'd24, 5'd16, 32'd0, t);
        push_dn(1'b1, t + 2);
        drain();

        issue(OP_ADD, SEW_32, LMUL_2, 1'b1, 5'd10, 5'd3, 5'd16, 32'd1, t);
        push_wr(5'd10, {4{32'h2}}, t + 4);
        push_wr(5'd11, {4{32'h3}}, t + 7);
        push_dn(1'b0, t + 8);
        drain();

        issue(OP_ADD, SEW_32, LMUL_2, 1'b0, 5'd20, 5'd24, 5'd16, 32'd0, t);
        push_wr(5'd20, {4{32'h11}}, t + 4);
        while (cyc < t + 6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_we", {127'd0, we}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pending_wr", 128'(wq.size()), 128'd0);
        chk("midrst_v21_kept", vrf[21], {4{32'hDEAD}});
        chk("midrst_v20_written", vrf[20], {4{32'h11}});
        chk("midrst_ready", {127'd0, req_ready}, 128'd1);

        run_t1();
        run_t3();

`ifdef VEXEC_SEQ_PERF_EN
        chk("perf_insts", 128'(perf_insts), 128'd2);
        chk("perf_wr", 128'(perf_wr), 128'd5);
`else
        chk("perf_insts_tied", 128'(perf_insts), 128'd0);
        chk("perf_wr_tied", 128'(perf_wr), 128'd0);
`endif
        chk("left_wr", 128'(wq.size()), 128'd0);
        chk("left_done", 128'(dq.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
